// File: rtl/ghost_sprite.sv
//-----------------------------------------------------------------------------
// ghost_sprite
//
// Renders one 16x16 arcade ghost and runs its behaviour-mode state machine.
// The sprite origin is derived from the ghost tile position. The pixel under
// the beam is looked up in the bitmap ROM, mapped to a 3-bit colour for the
// current mode, and registered, so col/visible lag shpos/svpos by one clk.
//
// Ports
//   clk        pixel clock (sole clock)
//   reset      asynchronous, active-high reset
//   ce         one-clk frame tick (advances walk animation and timers)
//   shpos      beam X, 10 bits
//   svpos      beam Y, 10 bits
//   xpos       ghost tile X, 5 bits
//   ypos       ghost tile Y, 5 bits
//   direction  0 right, 1 left, 2 up, 3 down (selects pupil placement)
//   frighten   event pulse: enter or restart frightened mode
//   eaten      event pulse: frightened ghost was eaten, becomes eyes
//   home       event pulse: eyes reached the pen, back to normal
//   col        registered {R,G,B} pixel, 000 when nothing is drawn
//   visible    registered, 1 when col is an opaque sprite pixel
//   mode       0 NORMAL, 1 FRIGHT, 2 FLASH, 3 EYES
//
// Build option
//   GHOST_FLASH_EN  when defined, the ghost flashes white near the end of
//                   frightened mode (FLASH state plus flash counter). When
//                   undefined, FRIGHT runs straight to NORMAL and the
//                   FLASH_FRAMES/FLASH_PERIOD parameters have no effect.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ghost_sprite #(
    parameter logic [2:0] BODY_COLOR    = 3'b100,
    parameter int         X_OFF         = 20,
    parameter int         Y_OFF         = 20,
    parameter int         ANIM_PERIOD   = 11,
    parameter int         FRIGHT_FRAMES = 600,
    parameter int         FLASH_FRAMES  = 120,
    parameter int         FLASH_PERIOD  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [9:0] shpos,
    input  logic [9:0] svpos,
    input  logic [4:0] xpos,
    input  logic [4:0] ypos,
    input  logic [1:0] direction,
    input  logic       frighten,
    input  logic       eaten,
    input  logic       home,
    output logic [2:0] col,
    output logic       visible,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        M_NORMAL = 2'd0,
        M_FRIGHT = 2'd1,
        M_FLASH  = 2'd2,
        M_EYES   = 2'd3
    } mode_t;

    localparam int         AW          = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [9:0] FRIGHT_LOAD = 10'(FRIGHT_FRAMES);

    // Body silhouette, bit 15 = leftmost column. Rows 14/15 are the skirt,
    // which alternates between the two walk frames.
    function automatic logic [15:0] body_mask(input logic anim_f, input logic [3:0] row);
        logic [15:0] m;
        case (row)
            4'd0:    m = 16'h07E0;
            4'd1:    m = 16'h1FF8;
            4'd2:    m = 16'h3FFC;
            4'd14:   m = anim_f ? 16'h766E : 16'h6E76;
            4'd15:   m = anim_f ? 16'h324C : 16'h4662;
            default: m = 16'h7FFE;
        endcase
        return m;
    endfunction

    // Normal bitmap ROM row: 16 two-bit pixels, column 0 in bits [31:30].
    // Codes: 0 transparent, 1 body, 2 pupil, 3 eye white. The two 4x4 eyes
    // sit 6 columns apart; direction shifts the eyes and moves the 2x2 pupils
    // toward the side the ghost is looking.
    function automatic logic [31:0] rom_row(input logic [1:0] dir, input logic anim_f,
                                            input logic [3:0] row);
        logic [15:0] m;
        logic [31:0] bits;
        logic [1:0]  pix;
        logic        w;
        logic        p;
        int          ex;
        int          ey;
        int          px;
        int          py;
        int          b;
        int          r;
        m    = body_mask(anim_f, row);
        bits = '0;
        r    = int'(row);
        case (dir)
            2'd0:    begin ex = 3; ey = 4; px = 2; py = 1; end
            2'd1:    begin ex = 1; ey = 4; px = 0; py = 1; end
            2'd2:    begin ex = 2; ey = 3; px = 1; py = 0; end
            default: begin ex = 2; ey = 5; px = 1; py = 2; end
        endcase
        for (int c = 0; c < 16; c++) begin
            w = 1'b0;
            p = 1'b0;
            for (int e = 0; e < 2; e++) begin
                b = ex + 6 * e;
                if (c >= b && c < b + 4 && r >= ey && r < ey + 4)
                    w = 1'b1;
                if (c >= b + px && c < b + px + 2 && r >= ey + py && r < ey + py + 2)
                    p = 1'b1;
            end
            if (p)
                pix = 2'd2;
            else if (w)
                pix = 2'd3;
            else if (m[15-c])
                pix = 2'd1;
            else
                pix = 2'd0;
            bits[31-2*c -: 2] = pix;
        end
        return bits;
    endfunction

    // Frightened-face ROM row: same silhouette, small square eyes and a
    // zig-zag mouth drawn as face pixels (code 3).
    function automatic logic [31:0] fright_row(input logic anim_f, input logic [3:0] row);
        logic [15:0] m;
        logic [31:0] bits;
        logic [1:0]  pix;
        logic        face;
        int          r;
        m    = body_mask(anim_f, row);
        bits = '0;
        r    = int'(row);
        for (int c = 0; c < 16; c++) begin
            face = ((r == 5 || r == 6) && (c == 4 || c == 5 || c == 10 || c == 11)) ||
                   (r == 10 && c >= 3 && c <= 13 && (c % 2) == 1) ||
                   (r == 11 && c >= 2 && c <= 12 && (c % 2) == 0);
            if (face)
                pix = 2'd3;
            else if (m[15-c])
                pix = 2'd1;
            else
                pix = 2'd0;
            bits[31-2*c -: 2] = pix;
        end
        return bits;
    endfunction

    function automatic logic [1:0] pick_pixel(input logic [31:0] r, input logic [3:0] x);
        logic [4:0]  amt;
        logic [31:0] sh;
        amt = 5'd30 - {x, 1'b0};
        sh  = r >> amt;
        return sh[1:0];
    endfunction

    // Returns {visible, col} for a pixel code in the given mode.
    function automatic logic [3:0] shade(input mode_t m, input logic phase_f,
                                         input logic [1:0] code);
        logic [3:0] o;
        o = 4'b0000;
        if (code != 2'd0) begin
            case (m)
                M_NORMAL: begin
                    case (code)
                        2'd1:    o = {1'b1, BODY_COLOR};
                        2'd2:    o = 4'b1001;
                        default: o = 4'b1111;
                    endcase
                end
                M_FRIGHT: o = (code == 2'd1) ? 4'b1001 : 4'b1111;
                M_FLASH: begin
                    if (phase_f)
                        o = (code == 2'd1) ? 4'b1111 : 4'b1100;
                    else
                        o = (code == 2'd1) ? 4'b1001 : 4'b1111;
                end
                default: begin
                    case (code)
                        2'd2:    o = 4'b1001;
                        2'd3:    o = 4'b1111;
                        default: o = 4'b0000;
                    endcase
                end
            endcase
        end
        return o;
    endfunction

    mode_t          mode_q;
    mode_t          mode_d;
    logic [9:0]     timer_q;
    logic [9:0]     timer_d;
    logic [AW-1:0]  anim_cnt;
    logic           anim;
    logic           phase;

`ifdef GHOST_FLASH_EN
    localparam int         FW         = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam logic [9:0] FLASH_LOAD = 10'(FLASH_FRAMES);

    logic [FW-1:0]  fcnt_q;
    logic [FW-1:0]  fcnt_d;
    logic           phase_q;
    logic           phase_d;

    assign phase = phase_q;
`else
    assign phase = 1'b0;
`endif

    // Walk animation: free-running over ce in every mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anim_cnt <= '0;
            anim     <= 1'b0;
        end else if (ce) begin
            if (anim_cnt == AW'(ANIM_PERIOD - 1)) begin
                anim_cnt <= '0;
                anim     <= ~anim;
            end else begin
                anim_cnt <= anim_cnt + AW'(1);
            end
        end
    end

    // Mode FSM. Events win over the ce tick, and eaten wins over frighten.
    // The FLASH transition fires on the ce that brings the timer down to
    // FLASH_FRAMES; expiry fires on the ce that brings it to zero.
    always_comb begin
        mode_d  = mode_q;
        timer_d = timer_q;
`ifdef GHOST_FLASH_EN
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
`endif
        case (mode_q)
            M_NORMAL: begin
                if (frighten) begin
                    mode_d  = M_FRIGHT;
                    timer_d = FRIGHT_LOAD;
                end
            end
            M_FRIGHT, M_FLASH: begin
                if (eaten) begin
                    mode_d  = M_EYES;
                    timer_d = '0;
                end else if (frighten) begin
                    mode_d  = M_FRIGHT;
                    timer_d = FRIGHT_LOAD;
                end else if (ce) begin
                    if (timer_q <= 10'd1) begin
                        mode_d  = M_NORMAL;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - 10'd1;
`ifdef GHOST_FLASH_EN
                        if (mode_q == M_FRIGHT && timer_d == FLASH_LOAD)
                            mode_d = M_FLASH;
                        if (mode_q == M_FLASH) begin
                            if (fcnt_q == FW'(FLASH_PERIOD - 1)) begin
                                fcnt_d  = '0;
                                phase_d = ~phase_q;
                            end else begin
                                fcnt_d = fcnt_q + FW'(1);
                            end
                        end
`endif
                    end
                end
            end
            M_EYES: begin
                if (home)
                    mode_d = M_NORMAL;
            end
            default: mode_d = M_NORMAL;
        endcase
`ifdef GHOST_FLASH_EN
        // Any path out of FLASH (including a restart) starts the next
        // flash sequence from phase 0.
        if (mode_d != M_FLASH) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= M_NORMAL;
            timer_q <= '0;
`ifdef GHOST_FLASH_EN
            fcnt_q  <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            mode_q  <= mode_d;
            timer_q <= timer_d;
`ifdef GHOST_FLASH_EN
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign mode = mode_q;

    // ---- stage p0: beam position -> sprite-local pixel -> colour ----
    logic [9:0]  ox_p0;
    logic [9:0]  oy_p0;
    logic [9:0]  dx_p0;
    logic [9:0]  dy_p0;
    logic        inside_p0;
    logic        fright_p0;
    logic [31:0] row_p0;
    logic [1:0]  code_p0;
    logic [3:0]  shade_p0;

    // Origin and differences wrap modulo 1024, so a ghost near the left or
    // top edge appears at the far end of the coordinate range.
    assign ox_p0     = {2'b00, xpos, 3'b000} - 10'(X_OFF);
    assign oy_p0     = {2'b00, ypos, 3'b000} - 10'(Y_OFF);
    assign dx_p0     = shpos - ox_p0;
    assign dy_p0     = svpos - oy_p0;
    assign inside_p0 = (dx_p0[9:4] == 6'd0) && (dy_p0[9:4] == 6'd0);
    assign fright_p0 = (mode_q == M_FRIGHT) || (mode_q == M_FLASH);
    assign row_p0    = fright_p0 ? fright_row(anim, dy_p0[3:0])
                                 : rom_row(direction, anim, dy_p0[3:0]);
    assign code_p0   = pick_pixel(row_p0, dx_p0[3:0]);
    assign shade_p0  = inside_p0 ? shade(mode_q, phase, code_p0) : 4'b0000;

    // ---- stage p1: registered pixel output ----
    logic [2:0] col_p1;
    logic       vld_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_p1 <= 3'b000;
            vld_p1 <= 1'b0;
        end else begin
            col_p1 <= shade_p0[2:0];
            vld_p1 <= shade_p0[3];
        end
    end

    assign col     = col_p1;
    assign visible = vld_p1;

endmodule

// File: tb/tb_ghost_sprite.sv
`timescale 1ns/1ps

module tb_ghost_sprite;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b0;
    logic [9:0] shpos = 10'd0;
    logic [9:0] svpos = 10'd0;
    logic [4:0] xpos = 5'd5;
    logic [4:0] ypos = 5'd5;
    logic [1:0] direction = 2'd0;
    logic       frighten = 1'b0;
    logic       eaten = 1'b0;
    logic       home = 1'b0;
    logic [2:0] col;
    logic       visible;
    logic [1:0] mode;

    int n_chk = 0;
    int n_bad = 0;

`ifdef GHOST_FLASH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    ghost_sprite dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .shpos     (shpos),
        .svpos     (svpos),
        .xpos      (xpos),
        .ypos      (ypos),
        .direction (direction),
        .frighten  (frighten),
        .eaten     (eaten),
        .home      (home),
        .col       (col),
        .visible   (visible),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic ce_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ce = 1'b1;
            @(negedge clk) ce = 1'b0;
        end
    endtask

    task automatic pulse(input logic f, input logic e, input logic h);
        @(negedge clk);
        frighten = f;
        eaten    = e;
        home     = h;
        @(negedge clk);
        frighten = 1'b0;
        eaten    = 1'b0;
        home     = 1'b0;
    endtask

    // Screen coordinates in; col/visible one clk later.
    task automatic probe(input string tag, input int x, input int y,
                         input logic [2:0] ec, input logic ev);
        @(negedge clk);
        shpos = 10'(x);
        svpos = 10'(y);
        @(posedge clk);
        #1;
        chk({tag, ".col"}, {29'd0, col}, {29'd0, ec});
        chk({tag, ".vis"}, {31'd0, visible}, {31'd0, ev});
    endtask

    initial begin
        shpos = 10'd20;
        svpos = 10'd20;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.mode", {30'd0, mode}, 32'd0);
        chk("rst.col", {29'd0, col}, 32'd0);
        chk("rst.vis", {31'd0, visible}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Sprite origin (20,20) with xpos=ypos=5; local (x,y) = screen - 20.
        probe("row0col0", 20, 20, 3'b000, 1'b0);
        probe("outside16", 36, 20, 3'b000, 1'b0);
        probe("body", 28, 30, 3'b100, 1'b1);
        probe("white_r", 23, 24, 3'b111, 1'b1);
        probe("pupil_r", 25, 25, 3'b001, 1'b1);
        direction = 2'd1;
        probe("body_l", 25, 25, 3'b100, 1'b1);
        probe("pupil_l", 21, 25, 3'b001, 1'b1);
        direction = 2'd2;
        probe("pupil_u", 23, 23, 3'b001, 1'b1);
        direction = 2'd3;
        probe("body_d", 23, 23, 3'b100, 1'b1);
        probe("pupil_d", 23, 28, 3'b001, 1'b1);
        direction = 2'd0;

        // Skirt pixel (1,15) is body in walk frame 0, transparent in frame 1.
        probe("anim0", 21, 35, 3'b100, 1'b1);
        ce_n(10);
        probe("anim10ce", 21, 35, 3'b100, 1'b1);
        ce_n(1);
        probe("anim11ce", 21, 35, 3'b000, 1'b0);

        // xpos=0 wraps the origin to 1004.
        xpos = 5'd0;
        probe("wrap1005", 1005, 30, 3'b100, 1'b1);
        probe("wrap1018", 1018, 30, 3'b100, 1'b1);
        probe("wrap0", 0, 30, 3'b000, 1'b0);
        probe("wrap1020", 1020, 30, 3'b000, 1'b0);
        xpos = 5'd5;

        pulse(1'b0, 1'b1, 1'b0);
        chk("eaten_normal", {30'd0, mode}, 32'd0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("home_normal", {30'd0, mode}, 32'd0);

        // Full frightened run.
        pulse(1'b1, 1'b0, 1'b0);
        chk("fright", {30'd0, mode}, 32'd1);
        probe("fr_body", 28, 28, 3'b001, 1'b1);
        probe("fr_face", 24, 25, 3'b111, 1'b1);
        ce_n(479);
        chk("ce479", {30'd0, mode}, 32'd1);
        ce_n(1);
        chk("ce480", {30'd0, mode}, FL ? 32'd2 : 32'd1);
        probe("fl_ph0", 28, 28, 3'b001, 1'b1);
        ce_n(14);
        probe("fl_494", 28, 28, 3'b001, 1'b1);
        ce_n(1);
        probe("fl_495", 28, 28, FL ? 3'b111 : 3'b001, 1'b1);
        probe("fl_face", 24, 25, FL ? 3'b100 : 3'b111, 1'b1);
        ce_n(15);
        probe("fl_510", 28, 28, 3'b001, 1'b1);
        ce_n(89);
        chk("ce599", {30'd0, mode}, FL ? 32'd2 : 32'd1);
        ce_n(1);
        chk("ce600", {30'd0, mode}, 32'd0);
        probe("norm_body", 28, 28, 3'b100, 1'b1);

        // Restart reloads the timer: 100 + 500 ce would otherwise expire.
        pulse(1'b1, 1'b0, 1'b0);
        ce_n(100);
        pulse(1'b1, 1'b0, 1'b0);
        ce_n(500);
        chk("reload", {30'd0, mode}, FL ? 32'd2 : 32'd1);
        probe("rl_ph1", 28, 28, FL ? 3'b111 : 3'b001, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("refright", {30'd0, mode}, 32'd1);
        ce_n(480);
        probe("rl_ph0", 28, 28, 3'b001, 1'b1);

        pulse(1'b1, 1'b1, 1'b0);
        chk("eaten_prio", {30'd0, mode}, 32'd3);
        probe("eyes_body", 28, 28, 3'b000, 1'b0);
        probe("eyes_white", 23, 24, 3'b111, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("eyes_fright", {30'd0, mode}, 32'd3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("home", {30'd0, mode}, 32'd0);

        // Asynchronous reset while flashing.
        pulse(1'b1, 1'b0, 1'b0);
        ce_n(480);
        chk("pre_rst", {30'd0, mode}, FL ? 32'd2 : 32'd1);
        probe("pre_rst", 28, 28, 3'b001, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("arst.mode", {30'd0, mode}, 32'd0);
        chk("arst.col", {29'd0, col}, 32'd0);
        chk("arst.vis", {31'd0, visible}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        ce_n(5);
        chk("post_rst", {30'd0, mode}, 32'd0);
        probe("post_rst", 28, 28, 3'b100, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ghost_sprite.md
GHOST_SPRITE -- requirements
Module: ghost_sprite

Interface
REQ-001 The module SHALL have parameter BODY_COLOR, default 3'b100, which is the 3-bit {R,G,B} body colour in NORMAL mode.
REQ-002 The module SHALL have parameter X_OFF, default 20, which is the screen X offset subtracted from xpos*8.
REQ-003 The module SHALL have parameter Y_OFF, default 20, which is the screen Y offset subtracted from ypos*8.
REQ-004 The module SHALL have parameter ANIM_PERIOD, default 11, which is the number of ce pulses per walk-frame toggle.
REQ-005 The module SHALL have parameter FRIGHT_FRAMES, default 600, which is the frightened duration in ce pulses (1..1023).
REQ-006 The module SHALL have parameter FLASH_FRAMES, default 120, which is the number of remaining frames at which flashing starts (must be < FRIGHT_FRAMES).
REQ-007 The module SHALL have parameter FLASH_PERIOD, default 15, which is the number of ce pulses per flash colour half-cycle.
REQ-008 The module SHALL have port clk, input, 1 bit: the pixel clock, sole clock.
REQ-009 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 The module SHALL have port ce, input, 1 bit: a one-clk frame tick.
REQ-011 The module SHALL have port shpos, input, 10 bits: the current beam X.
REQ-012 The module SHALL have port svpos, input, 10 bits: the current beam Y.
REQ-013 The module SHALL have port xpos, input, 5 bits: the ghost tile X.
REQ-014 The module SHALL have port ypos, input, 5 bits: the ghost tile Y.
REQ-015 The module SHALL have port direction, input, 2 bits: 0 right, 1 left, 2 up, 3 down (selects pupils).
REQ-016 The module SHALL have ports frighten, eaten and home, inputs, 1 bit each: event pulses, sampled every clk.
REQ-017 The module SHALL have port col, output, 3 bits: the {R,G,B} pixel, 000 when not drawn.
REQ-018 The module SHALL have port visible, output, 1 bit: 1 when col is an opaque sprite pixel.
REQ-019 The module SHALL have port mode, output, 2 bits: 0 NORMAL, 1 FRIGHT, 2 FLASH, 3 EYES.

Function
REQ-020 The sprite SHALL be 16x16 with origin OX = {xpos,3'b0}-X_OFF and OY = {ypos,3'b0}-Y_OFF, both 10-bit modulo arithmetic.
REQ-021 The pixel SHALL be inside when (shpos-OX)<16 and (svpos-OY)<16 (10-bit unsigned); local coordinates are the low 4 bits of each difference.
REQ-022 col and visible SHALL be registered, with 1 clk latency from shpos/svpos; outside pixels give col=000, visible=0.
REQ-023 The bitmap ROM SHALL hold 2-bit pixels (0 transparent, 1 body, 2 pupil, 3 eye white) indexed by {direction, anim, row}, i.e. 128 rows of 32 bits, plus 2 frightened-face rows sets selected by anim.
REQ-024 Colour mapping: NORMAL body=BODY_COLOR, white=111, pupil=001; FRIGHT body=001, face pixels=111; FLASH alternates FRIGHT colours and inverted (body=111, face=100) each FLASH_PERIOD frames; EYES draws only codes 2/3, with body transparent.
REQ-025 anim SHALL toggle on the ce where the anim counter equals ANIM_PERIOD-1, after which the counter returns to 0; otherwise the counter increments on ce.
REQ-026 The mode FSM SHALL follow: NORMAL -frighten-> FRIGHT; FRIGHT/FLASH -frighten-> FRIGHT with timer reloaded to FRIGHT_FRAMES and flash phase cleared; FRIGHT/FLASH -eaten-> EYES; EYES -home-> NORMAL.
REQ-027 The timer SHALL be 10 bits and decrement on ce in FRIGHT/FLASH; FRIGHT->FLASH when the timer equals FLASH_FRAMES; FRIGHT/FLASH->NORMAL on the ce where the timer reaches 0.
REQ-028 The FSM SHALL ignore eaten in NORMAL/EYES and ignore frighten in EYES.
REQ-029 Simultaneous events SHALL resolve with eaten taking priority over frighten, and eaten or frighten taking priority over timer expiry on the same clk.
REQ-030 The flash counter SHALL count ce pulses in FLASH only and toggle the phase at FLASH_PERIOD-1.

Reset
REQ-031 While reset=1, the module SHALL hold mode=NORMAL, anim=0, all counters 0, timer 0, flash phase 0, col=000, visible=0; reset asserted mid-frighten returns to NORMAL immediately.

Configuration
REQ-032 With GHOST_FLASH_EN defined, the FLASH state and flash counter SHALL exist; without it, FRIGHT SHALL run to timer 0 then go to NORMAL, mode never equals 2, and FLASH_FRAMES/FLASH_PERIOD SHALL be unused.

Verification
REQ-033 Bench: xpos=5, ypos=5, shpos=20, svpos=20, NORMAL -> col equals the ROM row0/col0 colour 1 clk later; shpos=36 -> col=000, visible=0.
REQ-034 Bench: 11 ce pulses -> anim toggles exactly once, on the 11th.
REQ-035 Bench: frighten, then 480 ce -> mode=2 (with GHOST_FLASH_EN) and body alternates 001/111 every 15 ce; after 600 ce total -> mode=0.
REQ-036 Bench: FRIGHT with eaten and frighten on the same clk -> mode=3; frighten in EYES -> still 3; home -> 0.
REQ-037 Bench: xpos=0 (OX wraps to 1004) -> pixels at shpos 1004..1019 drawn and shpos 0 not drawn.
REQ-038 Bench: reset pulse in FLASH -> mode=0, col=000 asynchronously, without waiting for a clk.
